rangefinder_sopc_timer_sequencer: RTL and testbench

Hardware sequencer that shares the 16-bit-register Avalon-MM interval timer among NREQ hardware requesters (ranging pulse gate, echo window, blanking interval, etc.) without CPU involvement. It arbitrates requests round-robin and programs the 32-bit period and a one-shot START into the timer. It waits for the timer's `timeout_pulse`, clears the timeout status, and returns a per-requester done pulse. It sits between the rangefinder datapath and the timer's s1 slave port; the CPU must not access that timer instance.

---
 rtl/rangefinder_sopc_timer_sequencer.sv | 133 +++++++++++++
 tb/tb_rangefinder_sopc_timer_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rangefinder_sopc_timer_sequencer.sv
// rangefinder_sopc_timer_sequencer: round-robin sharing of one Avalon interval timer among NREQ requesters
// Define SEQ_SNAPSHOT_EN to snapshot and read back the remaining count when a request is aborted.
module rangefinder_sopc_timer_sequencer #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   period,
  input  logic [NREQ-1:0]      cancel,
  output logic [NREQ-1:0]      done,
  output logic                 cancelled,
  output logic [31:0]          remaining,
  output logic                 busy,
  output logic [IDW-1:0]       active_id,
  output logic [2:0]           tmr_address,
  output logic                 tmr_chipselect,
  output logic                 tmr_write_n,
  output logic [15:0]          tmr_writedata,
  input  logic [15:0]          tmr_readdata,
  input  logic                 tmr_timeout_pulse
);
  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_GAP, S_WR_CTL, S_WAIT, S_CLR_TO, S_DONE,
    S_ABORT, S_RD_L, S_RD_H, S_STOP
  } state_e;
  state_e state_q, state_d;
  logic [IDW-1:0]  ptr_q, id_q, gnt_id;
  logic            gnt_any;
  logic [31:0]     gnt_raw, gnt_per, remaining_q;
  logic [15:0]     per_h_q, wd_q, wd_d;
  logic [2:0]      addr_q, addr_d;
  logic            wr_q, wr_d, busy_q, busy_d, cancelled_q;
  logic [NREQ-1:0] done_q, done_d;
  // Lowest offset from the pointer wins, so the scan runs downwards.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'((int'(ptr_q) + k) % NREQ);
      end
  end
  assign gnt_raw = period[32*int'(gnt_id) +: 32];
  assign gnt_per = (gnt_raw == 32'd0) ? 32'd1 : gnt_raw;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = gnt_any ? S_WR_PL : S_IDLE;
      S_WR_PL:  state_d = S_WR_PH;
      S_WR_PH:  state_d = S_GAP;
      S_GAP:    state_d = S_WR_CTL;
      S_WR_CTL: state_d = S_WAIT;
      S_WAIT:   state_d = tmr_timeout_pulse ? S_CLR_TO : cancel[id_q] ? S_ABORT : S_WAIT;
`ifdef SEQ_SNAPSHOT_EN
      S_ABORT:  state_d = S_RD_L;
      S_RD_L:   state_d = S_RD_H;
      S_RD_H:   state_d = S_STOP;
      S_STOP:   state_d = S_CLR_TO;
`else
      S_ABORT:  state_d = S_CLR_TO;
`endif
      S_CLR_TO: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end
  // Bus outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    wr_d   = 1'b0;
    addr_d = 3'd0;
    wd_d   = 16'h0000;
    case (state_d)
      S_WR_PL:  begin wr_d = 1'b1; addr_d = 3'd2; wd_d = gnt_per[15:0]; end
      S_WR_PH:  begin wr_d = 1'b1; addr_d = 3'd3; wd_d = per_h_q; end
      S_WR_CTL: begin wr_d = 1'b1; addr_d = 3'd1; wd_d = 16'h0004; end
      S_CLR_TO: wr_d = 1'b1;
`ifdef SEQ_SNAPSHOT_EN
      S_ABORT:  begin wr_d = 1'b1; addr_d = 3'd4; end
`else
      S_ABORT:  begin wr_d = 1'b1; addr_d = 3'd1; wd_d = 16'h0008; end
`endif
      S_RD_L:   addr_d = 3'd4;
      S_RD_H:   addr_d = 3'd5;
      S_STOP:   begin wr_d = 1'b1; addr_d = 3'd1; wd_d = 16'h0008; end
      default:  ;
    endcase
    done_d = (state_d == S_DONE) ? (NREQ'(1) << id_q) : '0;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ptr_q       <= '0;
      id_q        <= '0;
      per_h_q     <= 16'h0;
      cancelled_q <= 1'b0;
      remaining_q <= 32'h0;
      wr_q        <= 1'b0;
      addr_q      <= 3'd0;
      wd_q        <= 16'h0;
      done_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      done_q <= done_d;
      busy_q <= busy_d;
      if (state_q == S_IDLE && gnt_any) begin
        id_q        <= gnt_id;
        ptr_q       <= IDW'((int'(gnt_id) + 1) % NREQ);
        per_h_q     <= gnt_per[31:16];
        cancelled_q <= 1'b0;
        remaining_q <= 32'h0;
      end
      if (state_q == S_WAIT && state_d == S_ABORT) cancelled_q <= 1'b1;
      if (state_q == S_RD_H) remaining_q[15:0] <= tmr_readdata;
      if (state_q == S_STOP) remaining_q[31:16] <= tmr_readdata;
    end
  assign done           = done_q;
  assign cancelled      = cancelled_q;
  assign remaining      = remaining_q;
  assign busy           = busy_q;
  assign active_id      = id_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = wr_q;
  assign tmr_write_n    = !wr_q;
  assign tmr_writedata  = wd_q;
endmodule

// File: tb/tb_rangefinder_sopc_timer_sequencer.sv
// tb_rangefinder_sopc_timer_sequencer: directed bench with a behavioural interval timer and a done scoreboard
module tb_rangefinder_sopc_timer_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] req, cancel, done;
  logic [127:0] period;
  logic cancelled, busy, tmr_chipselect, tmr_write_n, tmr_timeout_pulse;
  logic [31:0] remaining;
  logic [1:0] active_id;
  logic [2:0] tmr_address;
  logic [15:0] tmr_writedata, tmr_readdata;
  always #5 clk = ~clk;

  rangefinder_sopc_timer_sequencer #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .period(period), .cancel(cancel),
    .done(done), .cancelled(cancelled), .remaining(remaining), .busy(busy),
    .active_id(active_id), .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata),
    .tmr_timeout_pulse(tmr_timeout_pulse)
  );

  // behavioural timer: one-shot countdown, pulse P+1 cycles after START, registered reads
  logic [15:0] t_pl, t_ph;
  logic [31:0] t_cnt, t_snap;
  logic t_run;
  assign tmr_timeout_pulse = t_run && t_cnt == 32'd0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      t_pl <= 16'h0; t_ph <= 16'h0; t_cnt <= 32'h0; t_snap <= 32'h0; t_run <= 1'b0; tmr_readdata <= 16'h0;
    end else begin
      tmr_readdata <= tmr_address == 3'd4 ? t_snap[15:0] : tmr_address == 3'd5 ? t_snap[31:16] : 16'h0;
      if (t_run) t_cnt <= (t_cnt == 32'd0) ? 32'd0 : t_cnt - 32'd1;
      if (tmr_timeout_pulse) t_run <= 1'b0;
      if (tmr_chipselect && !tmr_write_n)
        case (tmr_address)
          3'd2: t_pl <= tmr_writedata;
          3'd3: t_ph <= tmr_writedata;
          3'd4: t_snap <= t_cnt;
          3'd1: if (tmr_writedata[3]) t_run <= 1'b0;
                else if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= {t_ph, t_pl}; end
          default: ;
        endcase
    end

  int nvec = 0, nerr = 0, cyc = 0, pulse_cyc = 0, npulse = 0, nstop = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [1:0] id; logic canc; logic [31:0] lo; logic [31:0] hi;} exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic cs, input logic wn, input logic [2:0] a, input logic [15:0] d);
    chk(tag, {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {11'd0, cs, wn, a, d});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (done == 4'd0 && n < lim) begin step(); n++; end
    chk({tag, "_seen"}, {31'd0, done != 4'd0}, 32'd1);
  endtask

  // monitor: timeout pulses, STOP writes, and scoreboard pops on every done
  always @(negedge clk) begin
    exp_t e;
    if (tmr_timeout_pulse) begin npulse++; pulse_cyc = cyc; end
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 && tmr_writedata == 16'h0008) nstop++;
    if (done != 4'd0) begin
      nvec++;
      assert (sb.size() != 0) else begin
        nerr++;
        $error("FAIL unexpected_done: observed %0h expected none", done);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_vec", {28'd0, done}, 32'd1 << e.id);
        chk("cancelled", {31'd0, cancelled}, {31'd0, e.canc});
        nvec++;
        assert (remaining >= e.lo && remaining <= e.hi) else begin
          nerr++;
          $error("FAIL remaining: observed %0h expected %0h..%0h", remaining, e.lo, e.hi);
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: observed no end by cycle %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, stop0, np0;
    logic [31:0] ab_lo, ab_hi;
    reset_n = 1'b0; req = 4'h0; cancel = 4'h0; period = '0;
    repeat (2) step();
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_flags", {29'd0, cancelled, busy, 1'b0} | {30'd0, active_id}, 32'd0);
    chk("rst_remaining", remaining, 32'd0);
    chk_bus("rst_bus", 1'b0, 1'b1, 3'd0, 16'h0);
    reset_n = 1'b1;
    step();
    // round robin: all four held, five grants
    period = {32'd9, 32'd7, 32'd5, 32'd3};
    req = 4'hF;
    for (int g = 0; g < 5; g++) sb.push_back('{id: 2'(g % 4), canc: 1'b0, lo: 32'd0, hi: 32'd0});
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (!busy && n < 20) begin step(); n++; end
      chk("rr_id", {30'd0, active_id}, 32'(g % 4));
      wait_done("rr_done", 40);
      if (g == 4) req = 4'h0;
      step();
    end
    // single request, period 100
    period = '0; period[31:0] = 32'd100; req = 4'b0001;
    sb.push_back('{id: 2'd0, canc: 1'b0, lo: 32'd0, hi: 32'd0});
    step(); chk_bus("s_pl", 1'b1, 1'b0, 3'd2, 16'h0064);
    chk("s_busy_id", {29'd0, busy, active_id}, {29'd0, 1'b1, 2'd0});
    step(); chk_bus("s_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    step(); chk_bus("s_gap", 1'b0, 1'b1, 3'd0, 16'h0000);
    step(); chk_bus("s_ctl", 1'b1, 1'b0, 3'd1, 16'h0004);
    wait_done("s_done", 300);
    chk("s_latency", 32'(cyc - pulse_cyc), 32'd2);
    req = 4'h0;
    step();
    // zero period on requester 2, with cancels on other indices held
    period = '0; req = 4'b0100; cancel = 4'b1011;
    sb.push_back('{id: 2'd2, canc: 1'b0, lo: 32'd0, hi: 32'd0});
    step(); chk_bus("z_pl", 1'b1, 1'b0, 3'd2, 16'h0001);
    chk("z_id", {30'd0, active_id}, 32'd2);
    wait_done("z_done", 40);
    req = 4'h0; cancel = 4'h0;
    step();
    // abort on requester 3 about 1000 cycles into the wait
`ifdef SEQ_SNAPSHOT_EN
    ab_lo = 32'h0000_FC14; ab_hi = 32'h0000_FC1C;
`else
    ab_lo = 32'd0; ab_hi = 32'd0;
`endif
    period = '0; period[127:96] = 32'h0001_0000; req = 4'b1000;
    sb.push_back('{id: 2'd3, canc: 1'b1, lo: ab_lo, hi: ab_hi});
    step(); chk_bus("a_pl", 1'b1, 1'b0, 3'd2, 16'h0000);
    step(); chk_bus("a_ph", 1'b1, 1'b0, 3'd3, 16'h0001);
    step(); step();
    repeat (1000) step();
    cancel = 4'b1000; stop0 = nstop; np0 = npulse;
    wait_done("a_done", 20);
    cancel = 4'h0; req = 4'h0;
    chk("a_stop_writes", 32'(nstop - stop0), 32'd1);
    repeat (200) step();
    chk("a_no_pulse", 32'(npulse - np0), 32'd0);
    chk("a_timer_stopped", {31'd0, t_run}, 32'd0);
    // cancel in the same cycle as the timeout: timeout wins
    period = '0; period[31:0] = 32'd10; req = 4'b0001;
    sb.push_back('{id: 2'd0, canc: 1'b0, lo: 32'd0, hi: 32'd0});
    n = 0;
    while (!tmr_timeout_pulse && n < 100) begin step(); n++; end
    chk("x_pulse_seen", {31'd0, tmr_timeout_pulse}, 32'd1);
    cancel = 4'b0001; stop0 = nstop;
    step();
    cancel = 4'h0;
    chk_bus("x_clr_to", 1'b1, 1'b0, 3'd0, 16'h0000);
    wait_done("x_done", 10);
    chk("x_no_stop", 32'(nstop - stop0), 32'd0);
    req = 4'h0;
    step();
    // reset while waiting, then restart with a fresh pointer
    period = '0; period[63:32] = 32'd1000; req = 4'b0010;
    repeat (10) step();
    reset_n = 1'b0;
    step(); step();
    chk("rw_done_busy", {28'd0, done} | {31'd0, busy}, 32'd0);
    chk("rw_id_canc", {29'd0, cancelled, active_id}, 32'd0);
    chk_bus("rw_bus", 1'b0, 1'b1, 3'd0, 16'h0);
    period[63:32] = 32'd30; period[95:64] = 32'd4; req = 4'b0110;
    sb.push_back('{id: 2'd1, canc: 1'b0, lo: 32'd0, hi: 32'd0});
    sb.push_back('{id: 2'd2, canc: 1'b0, lo: 32'd0, hi: 32'd0});
    reset_n = 1'b1;
    step(); chk_bus("r_pl", 1'b1, 1'b0, 3'd2, 16'd30);
    chk("r_id", {30'd0, active_id}, 32'd1);
    wait_done("r_done1", 60);
    step();
    wait_done("r_done2", 40);
    req = 4'h0;
    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
